mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter   |
// | Revision    : 1.0                                                 |
// +-------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic P_MEM   = 1'b0;
    localparam logic P_FETCH = 1'b1;

    localparam int RAM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_arbiter_if : requester, RAM and status signals of mem_arbiter |
// | Revision       : 1.0                                              |
// +-------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    // Requester / RAM environment side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_arb_pick : winner selection; fixed m0-first, or round-robin   |
// |                when MEM_ARB_RR_EN is defined                      |
// | Revision     : 1.0                                                |
// +-------------------------------------------------------------------+
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic            winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        winner = P_MEM;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1] && !req[0]) begin
            winner = P_FETCH;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    always_comb begin
        winner = P_MEM;
        if (!req[0] && req[1]) begin
            winner = P_FETCH;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_arbiter : two-port single-RAM arbiter, IDLE/ISSUE/WAIT/DONE   |
// |               FSM; MEM_ARB_RR_EN selects round-robin arbitration  |
// | Revision    : 1.0                                                 |
// +-------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_LAT = RAM_LAT_DEFAULT,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(RAM_LAT - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_win;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [1:0]       r_gnt;
    logic [1:0]       r_rvalid;
    logic             r_ram_en;
    logic             r_ram_we;

    logic [1:0]       w_req;
    logic             w_winner;
    logic             w_last_grant;
    logic             w_sel_we;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic             r_last_grant;
    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b1;
`endif

    assign w_req = {bus.m1_req, bus.m0_req};

    mem_arb_pick u_pick (
        .req        (w_req),
        .last_grant (w_last_grant),
        .winner     (w_winner)
    );

    assign w_sel_we    = (w_winner == P_FETCH) ? bus.m1_we    : bus.m0_we;
    assign w_sel_addr  = (w_winner == P_FETCH) ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = (w_winner == P_FETCH) ? bus.m1_wdata : bus.m0_wdata;

    // Strobes, grants and completions are single-cycle pulses, cleared by default
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_win    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_win           <= w_winner;
                        r_we            <= w_sel_we;
                        r_addr          <= w_sel_addr;
                        r_wdata         <= w_sel_wdata;
                        r_ram_en        <= 1'b1;
                        r_ram_we        <= w_sel_we;
                        r_gnt[w_winner] <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        r_last_grant    <= w_winner;
`endif
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (RAM_LAT > 1) begin
                        r_cnt   <= C_WAIT_LOAD;
                        r_state <= ST_WAIT;
                    end else begin
                        r_rvalid[r_win] <= 1'b1;
                        r_state         <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt           <= '0;
                        r_rvalid[r_win] <= 1'b1;
                        r_state         <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = r_gnt[0];
    assign bus.m1_gnt    = r_gnt[1];
    assign bus.m0_rvalid = r_rvalid[0];
    assign bus.m1_rvalid = r_rvalid[1];

    // RAM data arrives exactly in DONE, so load data is steered through rather than registered
    assign bus.m0_rdata  = (r_rvalid[0] && !r_we) ? bus.ram_rdata : '0;
    assign bus.m1_rdata  = (r_rvalid[1] && !r_we) ? bus.ram_rdata : '0;

    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = (r_state == ST_ISSUE) ? r_addr  : '0;
    assign bus.ram_wdata = (r_state == ST_ISSUE) ? r_wdata : '0;

    assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter, RAM_LAT=2 and 1|
// | Revision       : 1.0                                              |
// +-------------------------------------------------------------------+
module tb_mem_arbiter;

    typedef struct {
        int          dut;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_cyc;
        int          rv_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t gq[$];
    exp_t rq[$];

    mem_arbiter_if #(.AW(32), .DW(32)) if0 ();
    mem_arbiter_if #(.AW(32), .DW(32)) if1 ();

    mem_arbiter #(.RAM_LAT(2), .AW(32), .DW(32)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mem_arbiter #(.RAM_LAT(1), .AW(32), .DW(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
    endfunction

    // RAM models: read data appears RAM_LAT cycles after the strobe, garbage otherwise
    logic [31:0] p0_a, p0_b, p1_a;
    always @(posedge clk) begin
        p0_a <= (if0.ram_en && !if0.ram_we) ? ram_fn(if0.ram_addr) : 32'hBADBAD00;
        p0_b <= p0_a;
        p1_a <= (if1.ram_en && !if1.ram_we) ? ram_fn(if1.ram_addr) : 32'hBADBAD00;
    end
    assign if0.ram_rdata = p0_b;
    assign if1.ram_rdata = p1_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s @cyc %0d: got event/timeout expected none", name, cyc);
    endtask

    function automatic exp_t mk(input int d, input logic p, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
        exp_t e;
        e.dut = d; e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        e.gnt_cyc = g; e.rv_cyc = r;
        return e;
    endfunction

    task automatic mon(input int d, input logic g0, input logic g1, input logic v0, input logic v1,
                       input logic [31:0] rd0, input logic [31:0] rd1, input logic en, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        chk("no_dual_gnt", 64'(g0 & g1), 64'd0);
        chk("no_dual_rvalid", 64'(v0 & v1), 64'd0);
        chk("ram_en_with_gnt", 64'(en), 64'(g0 | g1));
        chk("rdata_zero_idle", {rd1 & {32{~v1}}, rd0 & {32{~v0}}}, 64'd0);
        if (g0 | g1) begin
            if (gq.size() == 0) fail_now("unexpected_gnt");
            else begin
                e = gq.pop_front();
                chk("gnt_dut", 64'(d), 64'(e.dut));
                chk("gnt_port", 64'(g1), 64'(e.port));
                chk("gnt_cycle", 64'(cyc), 64'(e.gnt_cyc));
                chk("ram_we", 64'(we), 64'(e.we));
                chk("ram_addr", 64'(a), 64'(e.addr));
                chk("ram_wdata", 64'(wd), 64'(e.wdata));
            end
        end
        if (v0 | v1) begin
            if (rq.size() == 0) fail_now("unexpected_rvalid");
            else begin
                e = rq.pop_front();
                chk("rv_dut", 64'(d), 64'(e.dut));
                chk("rv_port", 64'(v1), 64'(e.port));
                chk("rv_cycle", 64'(cyc), 64'(e.rv_cyc));
                chk("rdata", 64'(v1 ? rd1 : rd0), 64'(e.rdata));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.m0_gnt, if0.m1_gnt, if0.m0_rvalid, if0.m1_rvalid, if0.m0_rdata, if0.m1_rdata,
            if0.ram_en, if0.ram_we, if0.ram_addr, if0.ram_wdata);
        mon(1, if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid, if1.m0_rdata, if1.m1_rdata,
            if1.ram_en, if1.ram_we, if1.ram_addr, if1.ram_wdata);
    end

    task automatic drive(input int d, input logic p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if (!p) begin if0.m0_req = req; if0.m0_we = we; if0.m0_addr = a; if0.m0_wdata = wd; end
            else    begin if0.m1_req = req; if0.m1_we = we; if0.m1_addr = a; if0.m1_wdata = wd; end
        end else begin
            if (!p) begin if1.m0_req = req; if1.m0_we = we; if1.m0_addr = a; if1.m0_wdata = wd; end
            else    begin if1.m1_req = req; if1.m1_we = we; if1.m1_addr = a; if1.m1_wdata = wd; end
        end
    endtask

    function automatic logic gnt_of(input int d, input logic p);
        if (d == 0) return p ? if0.m1_gnt : if0.m0_gnt;
        return p ? if1.m1_gnt : if1.m0_gnt;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? if0.busy : if1.busy;
    endfunction

    task automatic wait_gnt(input int d, input logic p);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_of(d, p)) return;
        end
        fail_now("gnt_timeout");
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy_of(d)) return;
        end
        fail_now("idle_timeout");
    endtask

    task automatic single(input int d, input logic p, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd);
        int   c;
        int   lat;
        exp_t e;
        lat = (d == 0) ? 2 : 1;
        @(negedge clk);
        c = cyc;
        e = mk(d, p, we, a, wd, rd, c + 1, c + 1 + lat);
        gq.push_back(e);
        rq.push_back(e);
        drive(d, p, 1'b1, we, a, wd);
        wait_gnt(d, p);
        drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_idle(d);
    endtask

    task automatic chk_quiet(input int d);
        if (d == 0) begin
            chk("q_gnt", {62'd0, if0.m1_gnt, if0.m0_gnt}, 64'd0);
            chk("q_rvalid", {62'd0, if0.m1_rvalid, if0.m0_rvalid}, 64'd0);
            chk("q_rdata", {if0.m1_rdata, if0.m0_rdata}, 64'd0);
            chk("q_ram_strobe", {62'd0, if0.ram_en, if0.ram_we}, 64'd0);
            chk("q_ram_bus", {if0.ram_addr, if0.ram_wdata}, 64'd0);
            chk("q_busy", 64'(if0.busy), 64'd0);
        end else begin
            chk("q1_gnt", {62'd0, if1.m1_gnt, if1.m0_gnt}, 64'd0);
            chk("q1_rvalid", {62'd0, if1.m1_rvalid, if1.m0_rvalid}, 64'd0);
            chk("q1_ram_strobe", {62'd0, if1.ram_en, if1.ram_we}, 64'd0);
            chk("q1_busy", 64'(if1.busy), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          n;
        logic [2:0]  ports;
        logic        p;
        exp_t        e;
        cyc   = 0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        repeat (3) @(negedge clk);
        chk_quiet(0);
        chk_quiet(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load, store, and a couple more directed accesses on the RAM_LAT=2 instance
        single(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        single(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0);
        single(0, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 32'h0);
        single(0, 1'b1, 1'b0, 32'h80, 32'h0, 32'hA5A50080);

        // Both requesters held for three accesses
`ifdef MEM_ARB_RR_EN
        ports = 3'b010;
`else
        ports = 3'b000;
`endif
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            p = ports[i];
            e = mk(0, p, 1'b0, p ? 32'h200 : 32'h100, 32'h0, p ? 32'hA5A50200 : 32'hA5A50100,
                   c + 1 + 4 * i, c + 3 + 4 * i);
            gq.push_back(e);
            rq.push_back(e);
        end
        drive(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(negedge clk);
            if (if0.m0_gnt || if0.m1_gnt) n++;
        end
        chk("contention_grants", 64'(n), 64'd3);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_idle(0);

        // m1 request raised while m0 is waiting on the RAM
        @(negedge clk);
        c = cyc;
        e = mk(0, 1'b0, 1'b0, 32'h30, 32'h0, 32'hA5A50030, c + 1, c + 3);
        gq.push_back(e);
        rq.push_back(e);
        e = mk(0, 1'b1, 1'b0, 32'h34, 32'h0, 32'hA5A50034, c + 5, c + 7);
        gq.push_back(e);
        rq.push_back(e);
        drive(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.m0_gnt) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (if0.m1_gnt) drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            if (cyc == c + 2) drive(0, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        end
        wait_idle(0);

        // Reset asserted while in WAIT aborts the access
        @(negedge clk);
        c = cyc;
        gq.push_back(mk(0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0, c + 1, c + 3));
        drive(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
        wait_gnt(0, 1'b1);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("busy_in_wait", 64'(if0.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_quiet(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        single(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

        // RAM_LAT=1 instance: ISSUE goes straight to DONE
        single(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        single(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (gq.size() == 0 && rq.size() == 0) break;
            @(negedge clk);
        end
        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
